// File: rtl/sobel_edge_detector.sv
// 3x3 Sobel edge classifier: combinational Gx/Gy/L1 magnitude, registered edge bit and done strobe.
// Optional build macro SOBEL_MAG_OUT_EN adds a registered mag_out debug port.
module sobel_edge_detector #(
   parameter int unsigned THRESHOLD = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sobel_en,
   input  logic [2:0][2:0][7:0]  comp_matrix,
   output logic                  output_pixel,
`ifdef SOBEL_MAG_OUT_EN
   output logic [10:0]           mag_out,
`endif
   output logic                  sobel_done
);

   localparam logic [10:0] ThreshW = 11'(THRESHOLD);

   logic [9:0]         right_sum, left_sum, top_sum, bottom_sum;
   logic signed [11:0] gx, gy;
   logic [11:0]        abs_gx, abs_gy;
   logic [10:0]        mag;

   logic pixel_d, pixel_q;
   logic done_d, done_q;
`ifdef SOBEL_MAG_OUT_EN
   logic [10:0] mag_d, mag_q;
`endif

   // Column 0 is the right edge of the window, row 2 the top.
   always_comb begin
      right_sum  = {2'b00, comp_matrix[2][0]} + {1'b0, comp_matrix[1][0], 1'b0}
                 + {2'b00, comp_matrix[0][0]};
      left_sum   = {2'b00, comp_matrix[2][2]} + {1'b0, comp_matrix[1][2], 1'b0}
                 + {2'b00, comp_matrix[0][2]};
      top_sum    = {2'b00, comp_matrix[2][2]} + {1'b0, comp_matrix[2][1], 1'b0}
                 + {2'b00, comp_matrix[2][0]};
      bottom_sum = {2'b00, comp_matrix[0][2]} + {1'b0, comp_matrix[0][1], 1'b0}
                 + {2'b00, comp_matrix[0][0]};
      gx     = signed'({2'b00, right_sum}) - signed'({2'b00, left_sum});
      gy     = signed'({2'b00, top_sum}) - signed'({2'b00, bottom_sum});
      abs_gx = gx[11] ? 12'(-gx) : 12'(gx);
      abs_gy = gy[11] ? 12'(-gy) : 12'(gy);
      mag    = abs_gx[10:0] + abs_gy[10:0];
   end

   always_comb begin
      done_d  = sobel_en;
      pixel_d = pixel_q;
`ifdef SOBEL_MAG_OUT_EN
      mag_d   = mag_q;
`endif
      if (sobel_en) begin
         pixel_d = (mag > ThreshW);
`ifdef SOBEL_MAG_OUT_EN
         mag_d   = mag;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef SOBEL_MAG_OUT_EN
         mag_q   <= '0;
`endif
      end else begin
         pixel_q <= pixel_d;
         done_q  <= done_d;
`ifdef SOBEL_MAG_OUT_EN
         mag_q   <= mag_d;
`endif
      end
   end

   assign output_pixel = pixel_q;
   assign sobel_done   = done_q;
`ifdef SOBEL_MAG_OUT_EN
   assign mag_out      = mag_q;
`endif

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Directed self-checking bench for sobel_edge_detector with hand-computed expectations.
module tb_sobel_edge_detector;

   logic                 clk;
   logic                 rst;
   logic                 sobel_en;
   logic [2:0][2:0][7:0] comp_matrix;
   logic                 output_pixel;
   logic                 sobel_done;
`ifdef SOBEL_MAG_OUT_EN
   logic [10:0]          mag_out;
`endif

   int total_cnt = 0;
   int bad_cnt   = 0;

   sobel_edge_detector #(.THRESHOLD(128)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .sobel_en     (sobel_en),
      .comp_matrix  (comp_matrix),
      .output_pixel (output_pixel),
`ifdef SOBEL_MAG_OUT_EN
      .mag_out      (mag_out),
`endif
      .sobel_done   (sobel_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Arguments are rows top->bottom, each listed left->right.
   task automatic set_win(input logic [7:0] tl, input logic [7:0] tm, input logic [7:0] tr,
                          input logic [7:0] ml, input logic [7:0] mm, input logic [7:0] mr,
                          input logic [7:0] bl, input logic [7:0] bm, input logic [7:0] br);
      comp_matrix[2][2] = tl; comp_matrix[2][1] = tm; comp_matrix[2][0] = tr;
      comp_matrix[1][2] = ml; comp_matrix[1][1] = mm; comp_matrix[1][0] = mr;
      comp_matrix[0][2] = bl; comp_matrix[0][1] = bm; comp_matrix[0][0] = br;
   endtask

   task automatic set_uniform(input logic [7:0] v);
      set_win(v, v, v, v, v, v, v, v, v);
   endtask

   // Drive enable at the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic en);
      @(negedge clk);
      sobel_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic done_exp, input logic pix_exp);
      check_val({tag, "_done"}, {31'd0, sobel_done}, {31'd0, done_exp});
      check_val({tag, "_pixel"}, {31'd0, output_pixel}, {31'd0, pix_exp});
   endtask

   initial begin
      rst      = 1'b1;
      sobel_en = 1'b1;
      set_uniform(8'd200);
      @(posedge clk);
      #1;
      expect_out("reset", 1'b0, 1'b0);

      @(negedge clk);
      rst = 1'b0;

      set_uniform(8'd1);
      step(1'b1);
      expect_out("ones", 1'b1, 1'b0);

      set_uniform(8'd255);
      step(1'b1);
      expect_out("all255", 1'b1, 1'b0);

      set_uniform(8'd10);
      step(1'b1);
      expect_out("all10", 1'b1, 1'b0);

      // Gx=846, Gy=88, mag=934
      set_win(8'd0, 8'd156, 8'd200, 8'd0, 8'd111, 8'd234, 8'd0, 8'd123, 8'd178);
      step(1'b1);
      expect_out("example", 1'b1, 1'b1);
`ifdef SOBEL_MAG_OUT_EN
      check_val("example_mag", {21'd0, mag_out}, 32'd934);
`endif

      // Right column 32: mag=128, strict compare gives 0.
      set_win(8'd0, 8'd0, 8'd32, 8'd0, 8'd0, 8'd32, 8'd0, 8'd0, 8'd32);
      step(1'b1);
      expect_out("thr_eq", 1'b1, 1'b0);

      // Right column 33: mag=132.
      set_win(8'd0, 8'd0, 8'd33, 8'd0, 8'd0, 8'd33, 8'd0, 8'd0, 8'd33);
      step(1'b1);
      expect_out("thr_above", 1'b1, 1'b1);

      // Enable low: done drops, pixel holds even with a uniform window present.
      set_uniform(8'd0);
      step(1'b0);
      expect_out("hold", 1'b0, 1'b1);
`ifdef SOBEL_MAG_OUT_EN
      check_val("hold_mag", {21'd0, mag_out}, 32'd132);
`endif

      // Back-to-back enables, each edge uses its own window.
      set_win(8'd0, 8'd156, 8'd200, 8'd0, 8'd111, 8'd234, 8'd0, 8'd123, 8'd178);
      step(1'b1);
      expect_out("b2b_first", 1'b1, 1'b1);
      set_uniform(8'd77);
      @(negedge clk);
      @(posedge clk);
      #1;
      expect_out("b2b_second", 1'b1, 1'b0);

      // Left-side gradient (negative Gx): left column 255, rest 0 -> mag=1020.
      set_win(8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0);
      step(1'b1);
      expect_out("neg_gx", 1'b1, 1'b1);

      // Asynchronous reset mid-cycle clears outputs before any clock edge.
      #2;
      rst = 1'b1;
      #1;
      expect_out("async_rst", 1'b0, 1'b0);
      @(negedge clk);
      rst      = 1'b0;
      sobel_en = 1'b0;
      @(posedge clk);
      #1;
      expect_out("post_rst", 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
